// File: rtl/pipelined_add_sub.sv
// Carry-pipelined add/sub: STAGES chunks of WIDTH/STAGES bits, valid/ready handshake.
// Define ADDSUB_OVF_EN to compile in the signed-overflow output.
module pipelined_add_sub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Mode,
  input  logic             Cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             m;
`ifdef ADDSUB_OVF_EN
    logic             o;
`endif
  } stg_t;

  stg_t             src [STAGES];
  stg_t             d   [STAGES];
  stg_t             q   [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [CW:0]      ch;
  logic             adv;

  assign adv       = !out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_q[L];
  assign Sum       = q[L].s;
  assign Cout      = q[L].c ^ q[L].m;
`ifdef ADDSUB_OVF_EN
  assign Ovf       = q[L].o;
`else
  assign Ovf       = 1'b0;
`endif

  // Stage 0 sees the raw operands; subtract folds into ~B and inverted carry.
  always_comb begin
    ch        = '0;
    src[0]    = '0;
    src[0].a  = A;
    src[0].b  = Mode ? ~B : B;
    src[0].c  = Mode ^ Cin;
    src[0].m  = Mode;
    for (int k = 1; k < STAGES; k++)
      src[k] = q[k-1];
    for (int k = 0; k < STAGES; k++) begin
      d[k] = src[k];
      ch = {1'b0, src[k].a[k*CW +: CW]}
         + {1'b0, src[k].b[k*CW +: CW]}
         + {{CW{1'b0}}, src[k].c};
      d[k].s[k*CW +: CW] = ch[CW-1:0];
      d[k].c = ch[CW];
`ifdef ADDSUB_OVF_EN
      // carry into the chunk MSB recovered from its sum bit
      d[k].o = ch[CW] ^ ch[CW-1]
             ^ src[k].a[k*CW + CW - 1]
             ^ src[k].b[k*CW + CW - 1];
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      vld_q <= '0;
      for (int k = 0; k < STAGES; k++)
        q[k] <= '0;
    end else if (adv) begin
      vld_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++)
        vld_q[k] <= vld_q[k-1];
      for (int k = 0; k < STAGES; k++)
        q[k] <= d[k];
    end
  end

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub: vector table, stalled stream, mid-flight reset.
// Ovf expectations follow whether ADDSUB_OVF_EN is defined.
module tb_pipelined_add_sub;

  logic       CLK = 1'b0;
  logic       RST_n;
  logic [7:0] A, B;
  logic       Mode, Cin, in_valid, in_ready;
  logic [7:0] Sum;
  logic       Cout, Ovf, out_valid, out_ready;

  int n_cmp = 0;
  int n_err = 0;

  pipelined_add_sub #(.WIDTH(8), .STAGES(2)) dut (
    .CLK(CLK), .RST_n(RST_n), .A(A), .B(B), .Mode(Mode), .Cin(Cin),
    .in_valid(in_valid), .in_ready(in_ready), .Sum(Sum), .Cout(Cout),
    .Ovf(Ovf), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic       cin;
    logic [7:0] s;
    logic       co;
    logic       ov;
  } vec_t;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
  } res_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic ovf_exp(input logic v);
`ifdef ADDSUB_OVF_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // Independent reference: signed/unsigned arithmetic on widened values.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic m, input logic cin);
    res_t r;
    int   sa, sb, sr, ua, ub, ur;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    if (!m) begin
      ur = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      r.co = ur > 255;
    end else begin
      ur = ua - ub - int'(cin);
      sr = sa - sb - int'(cin);
      r.co = ur < 0;
    end
    r.s  = 8'(ur);
    r.ov = ovf_exp(sr > 127 || sr < -128);
    return r;
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic m, input logic cin);
    A = a; B = b; Mode = m; Cin = cin; in_valid = 1'b1;
  endtask

  initial begin
    int   sent, recv, cyc;
    logic stalled;
    logic [7:0] hold_s;
    logic hold_c;
    vec_t ops [6];
    res_t exp_q [$];
    res_t e;

    vt[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
    vt[2] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b1, 1'b0};
    vt[3] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b1};
    vt[4] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[5] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
    vt[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[7] = '{8'h7F, 8'hFF, 1'b1, 1'b0, 8'h80, 1'b1, 1'b1};

    RST_n = 1'b0; A = '0; B = '0; Mode = 0; Cin = 0;
    in_valid = 0; out_ready = 1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_sum", 32'(Sum), 0);
    chk("rst_cout", 32'(Cout), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    @(negedge CLK);
    RST_n = 1'b1;

    // Single operations: latency 2, out_valid high exactly one cycle.
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      drive(vt[i].a, vt[i].b, vt[i].m, vt[i].cin);
      @(posedge CLK); #1;
      in_valid = 1'b0;
      A = 8'($urandom); B = 8'($urandom);
      @(negedge CLK);
      chk($sformatf("v%0d_early", i), 32'(out_valid), 0);
      @(negedge CLK);
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_sum", i), 32'(Sum), 32'(vt[i].s));
      chk($sformatf("v%0d_cout", i), 32'(Cout), 32'(vt[i].co));
      chk($sformatf("v%0d_ovf", i), 32'(Ovf), 32'(ovf_exp(vt[i].ov)));
      @(negedge CLK);
      chk($sformatf("v%0d_drop", i), 32'(out_valid), 0);
    end

    // Back-to-back stream with a three-cycle output stall.
    for (int i = 0; i < 6; i++)
      ops[i] = '{8'($urandom), 8'($urandom), 1'($urandom),
                 1'($urandom), 8'h00, 1'b0, 1'b0};
    sent = 0; recv = 0; stalled = 0; hold_s = '0; hold_c = 0;
    for (cyc = 0; cyc < 40 && recv < 6; cyc++) begin
      @(posedge CLK); #1;
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6)
        drive(ops[sent].a, ops[sent].b, ops[sent].m, ops[sent].cin);
      else
        in_valid = 1'b0;
      @(negedge CLK);
      chk($sformatf("s%0d_in_ready", cyc), 32'(in_ready),
          32'(!out_valid || out_ready));
      if (out_valid && !out_ready) begin
        if (stalled) begin
          chk($sformatf("s%0d_hold_sum", cyc), 32'(Sum), 32'(hold_s));
          chk($sformatf("s%0d_hold_cout", cyc), 32'(Cout), 32'(hold_c));
        end
        stalled = 1; hold_s = Sum; hold_c = Cout;
      end else begin
        stalled = 0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ops[sent].a, ops[sent].b,
                              ops[sent].m, ops[sent].cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("s%0d_spurious", cyc), 32'(out_valid), 0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("r%0d_sum", recv), 32'(Sum), 32'(e.s));
          chk($sformatf("r%0d_cout", recv), 32'(Cout), 32'(e.co));
          chk($sformatf("r%0d_ovf", recv), 32'(Ovf), 32'(e.ov));
        end
        recv++;
      end
    end
    chk("stream_count", 32'(recv), 6);
    @(posedge CLK); #1;
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset with two operations in flight.
    @(posedge CLK); #1;
    drive(8'h12, 8'h34, 1'b0, 1'b0);
    @(posedge CLK); #1;
    drive(8'h55, 8'h11, 1'b1, 1'b0);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    RST_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_sum", 32'(Sum), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    @(negedge CLK);
    RST_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk($sformatf("post_rst%0d_valid", i), 32'(out_valid), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
